// File: rtl/writeback_stage_reg_if.sv
// Bundle of the writeback stage's pipeline-side inputs and register-file/forwarding outputs.
interface writeback_stage_reg_if #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = 32
);
  logic                    i_stall;
  logic                    i_flush;
  logic                    i_valid;
  logic [31:0]             i_inst;
  logic [NUM_SRC*XLEN-1:0] i_src_data;
  logic [SEL_W-1:0]        i_wb_sel;
  logic                    i_rd_wren;

  logic [XLEN-1:0]         o_wb_data;
  logic [4:0]              o_rd_addr;
  logic                    o_rd_wren;
  logic                    o_fwd_valid;
  logic                    o_valid;
  logic                    o_ctrl;
  logic [CNT_W-1:0]        o_instret_cnt;
  logic [CNT_W-1:0]        o_ctrl_cnt;

  modport master (
    output i_stall, i_flush, i_valid, i_inst, i_src_data, i_wb_sel, i_rd_wren,
    input  o_wb_data, o_rd_addr, o_rd_wren, o_fwd_valid, o_valid, o_ctrl,
           o_instret_cnt, o_ctrl_cnt
  );

  modport slave (
    input  i_stall, i_flush, i_valid, i_inst, i_src_data, i_wb_sel, i_rd_wren,
    output o_wb_data, o_rd_addr, o_rd_wren, o_fwd_valid, o_valid, o_ctrl,
           o_instret_cnt, o_ctrl_cnt
  );
endinterface

// File: rtl/writeback_stage_reg.sv
// MEM/WB pipeline register with sub-word load extraction, writeback source select
// and retired / control-transfer instruction counters.
module writeback_stage_reg #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 4,
  parameter int SEL_W   = $clog2(NUM_SRC),
  parameter int CNT_W   = 32
) (
  input logic                 i_clk,
  input logic                 i_reset,
  writeback_stage_reg_if.slave bus
);
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_BR   = 7'h63;
  localparam logic [6:0] OP_JAL  = 7'h6F;
  localparam logic [6:0] OP_JALR = 7'h67;
  localparam logic [SEL_W:0] SRC_LIMIT = (SEL_W + 1)'(NUM_SRC);

  logic                    valid_q;
  logic [31:0]             inst_q;
  logic [NUM_SRC*XLEN-1:0] src_q;
  logic [SEL_W-1:0]        sel_q;
  logic                    rd_wren_q;
  logic [1:0]              ld_off_q;
  logic [CNT_W-1:0]        instret_q;
  logic [CNT_W-1:0]        ctrl_cnt_q;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic            sel_ok;
  logic            is_ctrl;
  logic            retire;
  logic [XLEN-1:0] word0;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic [XLEN-1:0] ld_data;
  logic [XLEN-1:0] src_sel;
  logic            unused_inst_bits;

  // Flush clears every field so a bubble can never look like a write to x0 or a load.
  always_ff @(posedge i_clk) begin
    if (!i_reset || bus.i_flush) begin
      valid_q   <= 1'b0;
      inst_q    <= '0;
      src_q     <= '0;
      sel_q     <= '0;
      rd_wren_q <= 1'b0;
      ld_off_q  <= '0;
    end else if (!bus.i_stall) begin
      valid_q   <= bus.i_valid;
      inst_q    <= bus.i_inst;
      src_q     <= bus.i_src_data;
      sel_q     <= bus.i_wb_sel;
      rd_wren_q <= bus.i_rd_wren;
      ld_off_q  <= bus.i_src_data[XLEN +: 2];
    end
  end

  assign retire = valid_q & ~bus.i_stall & ~bus.i_flush;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      instret_q  <= '0;
      ctrl_cnt_q <= '0;
    end else if (retire) begin
      instret_q <= instret_q + CNT_W'(1);
      if (is_ctrl) ctrl_cnt_q <= ctrl_cnt_q + CNT_W'(1);
    end
  end

  assign opcode           = inst_q[6:0];
  assign rd               = inst_q[11:7];
  assign unused_inst_bits = ^inst_q[31:15];
  assign sel_ok           = ({1'b0, sel_q} < SRC_LIMIT);
  assign is_ctrl          = valid_q & ((opcode == OP_BR) | (opcode == OP_JAL) | (opcode == OP_JALR));

  assign word0   = src_q[XLEN-1:0];
  assign ld_byte = word0[{ld_off_q, 3'b000} +: 8];
  assign ld_half = word0[{ld_off_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = word0;
    case (inst_q[14:12])
      3'b000:  ld_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{(XLEN-16){ld_half[15]}}, ld_half};
      3'b100:  ld_data = {{(XLEN-8){1'b0}}, ld_byte};
      3'b101:  ld_data = {{(XLEN-16){1'b0}}, ld_half};
      default: ld_data = word0;
    endcase
  end

  // Out-of-range selects match no source and fall through to zero.
  always_comb begin
    src_sel = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (sel_q == SEL_W'(k)) src_sel = src_q[k*XLEN +: XLEN];
    end
  end

  assign bus.o_wb_data     = !sel_ok ? '0 :
                             ((opcode == OP_LOAD) && (sel_q == '0)) ? ld_data : src_sel;
  assign bus.o_rd_addr     = rd;
  assign bus.o_rd_wren     = valid_q & rd_wren_q & (rd != 5'd0) & sel_ok;
  assign bus.o_fwd_valid   = bus.o_rd_wren;
  assign bus.o_valid       = valid_q;
  assign bus.o_ctrl        = is_ctrl;
  assign bus.o_instret_cnt = instret_q;
  assign bus.o_ctrl_cnt    = ctrl_cnt_q;
endmodule

// File: tb/tb_writeback_stage_reg.sv
// Self-checking bench: table vectors through a scoreboard on the default instance,
// plus hand sequences for stall/flush/reset, counter wrap and illegal select.
module tb_writeback_stage_reg;
  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] inst;
    logic [31:0] s0, s1, s2, s3;
    logic [1:0]  sel;
    logic        rd_wren;
    logic [31:0] exp_data;
    logic        exp_wren;
    logic        exp_ctrl;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        wren;
    logic        valid;
    logic        ctrl;
    logic [31:0] instret;
    logic [31:0] ctrl_cnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  exp_t  sb[$];
  string name_q[$];
  exp_t  held = '0;
  vec_t  vecs[$];

  writeback_stage_reg_if wb ();
  writeback_stage_reg_if #(.CNT_W(4)) wbc ();
  writeback_stage_reg_if #(.NUM_SRC(3)) wbi ();

  writeback_stage_reg dut (.i_clk(clk), .i_reset(reset_n), .bus(wb));
  writeback_stage_reg #(.CNT_W(4)) dut_cnt (.i_clk(clk), .i_reset(reset_n), .bus(wbc));
  writeback_stage_reg #(.NUM_SRC(3)) dut_ill (.i_clk(clk), .i_reset(reset_n), .bus(wbi));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] mk_inst(input logic [6:0] op, input logic [4:0] rd,
                                          input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  function automatic vec_t mk_vec(input string name, input logic valid, input logic [31:0] inst,
                                  input logic [31:0] s0, input logic [31:0] s1,
                                  input logic [31:0] s2, input logic [31:0] s3,
                                  input logic [1:0] sel, input logic rd_wren,
                                  input logic [31:0] exp_data, input logic exp_wren,
                                  input logic exp_ctrl);
    vec_t v;
    v.name = name; v.valid = valid; v.inst = inst;
    v.s0 = s0; v.s1 = s1; v.s2 = s2; v.s3 = s3;
    v.sel = sel; v.rd_wren = rd_wren;
    v.exp_data = exp_data; v.exp_wren = exp_wren; v.exp_ctrl = exp_ctrl;
    return v;
  endfunction

  task automatic check(input string what, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", what, act, exp);
    end
  endtask

  // Drive one cycle of inputs and push what the stage must show after the next edge.
  task automatic applyStimulus(input vec_t v, input logic stall, input logic flush,
                               input logic rst_n);
    exp_t e;
    logic retire;
    @(negedge clk);
    reset_n         = rst_n;
    wb.i_stall      = stall;
    wb.i_flush      = flush;
    wb.i_valid      = v.valid;
    wb.i_inst       = v.inst;
    wb.i_src_data   = {v.s3, v.s2, v.s1, v.s0};
    wb.i_wb_sel     = v.sel;
    wb.i_rd_wren    = v.rd_wren;
    retire = held.valid && !stall && !flush;
    e = '0;
    if (rst_n) begin
      if (flush) e = '0;
      else if (stall) e = held;
      else begin
        e.data  = v.exp_data;
        e.rd    = v.inst[11:7];
        e.wren  = v.exp_wren;
        e.valid = v.valid;
        e.ctrl  = v.exp_ctrl;
      end
      e.instret  = held.instret + (retire ? 32'd1 : 32'd0);
      e.ctrl_cnt = held.ctrl_cnt + ((retire && held.ctrl) ? 32'd1 : 32'd0);
    end
    held = e;
    sb.push_back(e);
    name_q.push_back(v.name);
  endtask

  task automatic checkOutput();
    exp_t  e;
    string n;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
      return;
    end
    e = sb.pop_front();
    n = name_q.pop_front();
    check({n, ".data"},     wb.o_wb_data, e.data);
    check({n, ".rd"},       32'(wb.o_rd_addr), 32'(e.rd));
    check({n, ".wren"},     32'(wb.o_rd_wren), 32'(e.wren));
    check({n, ".fwd"},      32'(wb.o_fwd_valid), 32'(e.wren));
    check({n, ".valid"},    32'(wb.o_valid), 32'(e.valid));
    check({n, ".ctrl"},     32'(wb.o_ctrl), 32'(e.ctrl));
    check({n, ".instret"},  wb.o_instret_cnt, e.instret);
    check({n, ".ctrl_cnt"}, wb.o_ctrl_cnt, e.ctrl_cnt);
  endtask

  task automatic runStep(input vec_t v, input logic stall, input logic flush, input logic rst_n);
    applyStimulus(v, stall, flush, rst_n);
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    vec_t idle, jal, add;
    logic [31:0] x1, x2, x3;
    x1 = 32'hAAAA_0001; x2 = 32'hAAAA_0002; x3 = 32'hAAAA_0003;

    wb.i_stall = 0; wb.i_flush = 0; wb.i_valid = 0; wb.i_inst = '0;
    wb.i_src_data = '0; wb.i_wb_sel = '0; wb.i_rd_wren = 0;
    wbc.i_stall = 0; wbc.i_flush = 0; wbc.i_valid = 0; wbc.i_inst = '0;
    wbc.i_src_data = '0; wbc.i_wb_sel = '0; wbc.i_rd_wren = 0;
    wbi.i_stall = 0; wbi.i_flush = 0; wbi.i_valid = 0; wbi.i_inst = '0;
    wbi.i_src_data = '0; wbi.i_wb_sel = '0; wbi.i_rd_wren = 0;

    idle = mk_vec("idle", 0, 32'd0, 0, 0, 0, 0, 2'd0, 0, 32'd0, 0, 0);
    jal  = mk_vec("jal", 1, mk_inst(7'h6F, 5'd1, 3'd0), x1, x2, 32'h0000_0104, x3,
                  2'd2, 1, 32'h0000_0104, 1, 1);
    add  = mk_vec("add", 1, mk_inst(7'h33, 5'd6, 3'd0), x1, 32'h0000_0042, x2, x3,
                  2'd1, 1, 32'h0000_0042, 1, 0);

    vecs.push_back(mk_vec("lb_off3", 1, mk_inst(7'h03, 5'd3, 3'd0), 32'h80FF_1234, 32'd3, x2, x3, 2'd0, 1, 32'hFFFF_FF80, 1, 0));
    vecs.push_back(mk_vec("lbu_off3", 1, mk_inst(7'h03, 5'd3, 3'd4), 32'h80FF_1234, 32'd3, x2, x3, 2'd0, 1, 32'h0000_0080, 1, 0));
    vecs.push_back(mk_vec("lh_off2", 1, mk_inst(7'h03, 5'd4, 3'd1), 32'h8001_0000, 32'd2, x2, x3, 2'd0, 1, 32'hFFFF_8001, 1, 0));
    vecs.push_back(mk_vec("lhu_off2", 1, mk_inst(7'h03, 5'd4, 3'd5), 32'h8001_0000, 32'd2, x2, x3, 2'd0, 1, 32'h0000_8001, 1, 0));
    vecs.push_back(mk_vec("lw", 1, mk_inst(7'h03, 5'd8, 3'd2), 32'hDEAD_BEEF, 32'd0, x2, x3, 2'd0, 1, 32'hDEAD_BEEF, 1, 0));
    vecs.push_back(mk_vec("lb_off1", 1, mk_inst(7'h03, 5'd9, 3'd0), 32'h1234_5678, 32'd1, x2, x3, 2'd0, 1, 32'h0000_0056, 1, 0));
    vecs.push_back(mk_vec("lh_off0", 1, mk_inst(7'h03, 5'd9, 3'd1), 32'h0000_F00D, 32'd0, x2, x3, 2'd0, 1, 32'hFFFF_F00D, 1, 0));
    vecs.push_back(mk_vec("load_sel1", 1, mk_inst(7'h03, 5'd9, 3'd0), 32'h80FF_1234, 32'h0000_1003, x2, x3, 2'd1, 1, 32'h0000_1003, 1, 0));
    vecs.push_back(mk_vec("add_rd5", 1, mk_inst(7'h33, 5'd5, 3'd0), x1, 32'h0000_1234, x2, x3, 2'd1, 1, 32'h0000_1234, 1, 0));
    vecs.push_back(mk_vec("add_rd0", 1, mk_inst(7'h33, 5'd0, 3'd0), x1, 32'h0000_1234, x2, x3, 2'd1, 1, 32'h0000_1234, 0, 0));
    vecs.push_back(mk_vec("aux_sel3", 1, mk_inst(7'h37, 5'd7, 3'd0), x1, x2, x3, 32'hCAFE_0000, 2'd3, 1, 32'hCAFE_0000, 1, 0));
    vecs.push_back(mk_vec("jal_pc4", 1, mk_inst(7'h6F, 5'd1, 3'd0), x1, x2, 32'h0000_0104, x3, 2'd2, 1, 32'h0000_0104, 1, 1));
    vecs.push_back(mk_vec("branch", 1, mk_inst(7'h63, 5'd4, 3'd0), x1, 32'h0000_0055, x2, x3, 2'd1, 0, 32'h0000_0055, 0, 1));
    vecs.push_back(mk_vec("jalr", 1, mk_inst(7'h67, 5'd1, 3'd0), x1, x2, 32'h0000_0200, x3, 2'd2, 1, 32'h0000_0200, 1, 1));
    vecs.push_back(mk_vec("bubble", 0, mk_inst(7'h33, 5'd5, 3'd0), x1, 32'h0000_0077, x2, x3, 2'd1, 1, 32'h0000_0077, 0, 0));
    vecs.push_back(mk_vec("no_wren", 1, mk_inst(7'h33, 5'd5, 3'd0), x1, 32'h0000_0077, x2, x3, 2'd1, 0, 32'h0000_0077, 0, 0));
    vecs.push_back(mk_vec("br_invalid", 0, mk_inst(7'h63, 5'd2, 3'd0), x1, 32'h0000_0011, x2, x3, 2'd1, 0, 32'h0000_0011, 0, 0));

    // Reset held for two edges, then released into idle.
    runStep(idle, 0, 0, 0);
    runStep(idle, 0, 0, 0);
    runStep(idle, 0, 0, 1);
    runStep(idle, 0, 0, 1);

    foreach (vecs[i]) runStep(vecs[i], 0, 0, 1);
    runStep(idle, 0, 0, 1);

    // JAL held by a three-cycle stall, then retired on release.
    runStep(jal, 0, 0, 1);
    for (int i = 0; i < 3; i++) runStep(add, 1, 0, 1);
    runStep(add, 0, 0, 1);
    runStep(idle, 0, 0, 1);

    // Stall and flush together drop the JAL without counting it.
    runStep(jal, 0, 0, 1);
    runStep(add, 1, 1, 1);
    runStep(idle, 0, 0, 1);

    // Reset arriving during a stall clears state and counters.
    runStep(add, 0, 0, 1);
    runStep(jal, 1, 0, 1);
    runStep(jal, 1, 0, 0);
    runStep(idle, 0, 0, 1);

    // Four-bit counters: seventeen retirements wrap to one.
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      wbc.i_valid    = (i < 17);
      wbc.i_inst     = mk_inst(7'h6F, 5'd1, 3'd0);
      wbc.i_src_data = {32'd3, 32'd2, 32'd1, 32'd0};
      wbc.i_wb_sel   = 2'd2;
      wbc.i_rd_wren  = 1'b1;
      @(posedge clk);
      #1;
      if (i == 15) check("wrap_pre_instret", 32'(wbc.o_instret_cnt), 32'd15);
    end
    check("wrap_instret", 32'(wbc.o_instret_cnt), 32'd1);
    check("wrap_ctrl_cnt", 32'(wbc.o_ctrl_cnt), 32'd1);

    // Three sources: select 2 is legal, select 3 yields zero data and no write.
    @(negedge clk);
    wbi.i_valid    = 1'b1;
    wbi.i_inst     = mk_inst(7'h33, 5'd5, 3'd0);
    wbi.i_src_data = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    wbi.i_wb_sel   = 2'd2;
    wbi.i_rd_wren  = 1'b1;
    @(posedge clk);
    #1;
    check("ill_sel2_data", wbi.o_wb_data, 32'h3333_3333);
    check("ill_sel2_wren", 32'(wbi.o_rd_wren), 32'd1);
    @(negedge clk);
    wbi.i_wb_sel = 2'd3;
    @(posedge clk);
    #1;
    check("ill_sel3_data", wbi.o_wb_data, 32'd0);
    check("ill_sel3_wren", 32'(wbi.o_rd_wren), 32'd0);
    check("ill_sel3_fwd", 32'(wbi.o_fwd_valid), 32'd0);
    check("ill_sel3_valid", 32'(wbi.o_valid), 32'd1);
    @(negedge clk);
    wbi.i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ill_instret", wbi.o_instret_cnt, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/writeback_stage_reg.md
# writeback_stage_reg

Registered, parametrised writeback stage for the RV32I pipeline. Holds the MEM/WB pipeline register and extracts and extends sub-word load data. Selects among `NUM_SRC` writeback sources and drives the register-file write port and forwarding path. Also keeps retired-instruction and control-transfer counters. Sits between the memory stage and the register file / hazard unit.

## Interface
- `XLEN`, default 32: data width of every source and of the writeback data.
- `NUM_SRC`, default 4: number of writeback sources. Minimum 3. Source 0 = raw load word, 1 = ALU result, 2 = PC+4, 3 and up = auxiliary (CSR/immediate).
- `SEL_W`, default `$clog2(NUM_SRC)`: width of the source select.
- `CNT_W`, default 32: width of each event counter.
- `i_clk`, input, 1: the single clock. All state updates on the rising edge.
- `i_reset`, input, 1: synchronous, active-low reset.
- `i_stall`, input, 1: hold the pipeline register.
- `i_flush`, input, 1: insert a bubble.
- `i_valid`, input, 1: the incoming instruction is real.
- `i_inst`, input, 32: incoming instruction word.
- `i_src_data`, input, `NUM_SRC*XLEN`: packed sources; source k occupies bits `[k*XLEN +: XLEN]`.
- `i_wb_sel`, input, `SEL_W`: source select.
- `i_rd_wren`, input, 1: destination-write enable from decode.
- `o_wb_data`, output, `XLEN`: data written to rd.
- `o_rd_addr`, output, 5: destination register, `inst[11:7]`.
- `o_rd_wren`, output, 1: qualified register-file write enable.
- `o_fwd_valid`, output, 1: forwarding hit allowed; equals `o_rd_wren`.
- `o_valid`, output, 1: the stage holds a real instruction.
- `o_ctrl`, output, 1: the held instruction is BR (0x63), JAL (0x6F) or JALR (0x67), and `o_valid` is 1.
- `o_instret_cnt`, output, `CNT_W`: count of retired instructions.
- `o_ctrl_cnt`, output, `CNT_W`: count of retired control-transfer instructions.

## Operation
- Pipeline register: `valid`, `inst`, `src_data`, `wb_sel`, `rd_wren`, `ld_off`. `ld_off` is captured from `src1[1:0]`, the low bits of the ALU address.
- Update priority, on each rising edge:
  - `i_reset`=0: `valid`=0, all fields 0, both counters 0.
  - else `i_flush`=1: `valid`=0; other fields don't-care, implemented as 0.
  - else `i_stall`=1: hold every field.
  - else: capture all inputs.
- Load extraction applies only when the registered opcode is 0x03 and `wb_sel`=0.
  - The byte or halfword is taken from source 0 at offset `ld_off`.
  - funct3 000 LB: sign-extend byte `[8*off +: 8]`.
  - funct3 001 LH: sign-extend half `[16*off[1] +: 16]`.
  - funct3 100 LBU and 101 LHU: zero-extend the same slices.
  - funct3 010 LW and any other funct3: pass the full word.
- For all other selections, source k passes through unchanged.
- `wb_sel` >= `NUM_SRC`: `o_wb_data` = 0 and `o_rd_wren` = 0.
- `o_rd_wren` = `valid & rd_wren & (rd != 0) & (wb_sel < NUM_SRC)`. Writes to x0 are never issued.
- Retire event: `valid=1` and `i_stall=0` and `i_flush=0` in the same cycle.
  - On a retire event `o_instret_cnt` increments by 1.
  - `o_ctrl_cnt` also increments by 1 if `o_ctrl`=1.
  - Both counters wrap modulo 2^`CNT_W`.

## Timing
- Latency is one cycle: inputs sampled at edge N appear on the outputs after edge N.
- All outputs are combinational from the pipeline register, with no input-to-output path. Exception: the counter increment condition uses `i_stall` and `i_flush`, but only at the next edge.
- Output values after reset: `o_valid`=0, `o_rd_wren`=0, `o_fwd_valid`=0, `o_ctrl`=0, `o_rd_addr`=0, `o_wb_data`=0, both counters 0.
- Stall holds every output stable. A held write may be re-issued each cycle; it is idempotent.
- Flush and stall asserted together: flush wins. The bubble enters and the held instruction is dropped without retiring.
- Reset asserted mid-stall or mid-flush clears everything at that edge.
- Counter at all-ones plus a retire event: the next value is 0.

## Test plan
- Reset then idle: hold `i_reset`=0 for 2 cycles, then release with `i_valid`=0 → all outputs 0, counters stay 0.
- Load extraction: LB, off=3, src0=0x80FF_1234 → `o_wb_data`=0xFFFF_FF80. Same with LBU → 0x0000_0080. LH, off=2, src0=0x8001_0000 → 0xFFFF_8001.
- Source select and x0: ADD with rd=5, sel=1, src1=0x1234 → `o_rd_wren`=1, data 0x1234. The same with rd=0 → `o_rd_wren`=0. Select=3 → auxiliary data is passed.
- Stall and flush: JAL captured, then `i_stall` for 3 cycles → outputs held and counters unchanged. Stall released → `o_instret_cnt`+1, `o_ctrl_cnt`+1. Stall and flush together → `o_valid`=0 next cycle and no count.
- Counter wrap with `CNT_W`=4: retire 17 back-to-back valid instructions → `o_instret_cnt`=1.
- Illegal select with `NUM_SRC`=3, sel=3 → `o_wb_data`=0 and `o_rd_wren`=0; the instruction still retires and counts.
